// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that lets NUM_REQ requesters write bursts of up to
//   BURST_LEN beats into a single FIFO write port. Each burst is followed by
//   exactly one idle cycle, so the grant always passes through zero before it
//   moves to a new owner.
//
// Parameters
//   DATA_WIDTH  width of one write word
//   NUM_REQ     number of requesters (2..8)
//   BURST_LEN   maximum beats per grant (1..16)
//
// Ports
//   wclk      in   write clock, all state on rising edge
//   wrst_n    in   asynchronous active-low reset (release synchronous to wclk)
//   req       in   per-requester request, held while data is pending
//   req_data  in   per-requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt       out  one-hot grant for the current burst owner
//   full      in   FIFO full flag
//   w_en      out  FIFO write enable
//   data_in   out  FIFO write data
//   stat_cnt  out  per-requester accepted-beat counters, 16 bits each,
//                  saturating (present only with FIFO_WR_ARB_STATS_EN)
//
// Build option
//   FIFO_WR_ARB_STATS_EN  adds the stat_cnt output and its counters.
//
// States
//   IDLE  | no owner; pick next requester at/after ptr, gnt = 0
//   BURST | owner holds gnt; a beat is written whenever req[owner] & !full
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          full,
  output logic                          w_en,
  output logic [DATA_WIDTH-1:0]         data_in
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         stat_cnt
`endif
);

  localparam int OWN_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);
  localparam logic [OWN_W-1:0] LAST_IDX = OWN_W'(NUM_REQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [OWN_W-1:0]  owner_q, owner_d;
  logic [OWN_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic                  req_own;
  logic [DATA_WIDTH-1:0] data_own;
  logic [NUM_REQ-1:0]    owner_oh;
  logic                  pick_vld;
  logic [OWN_W-1:0]      pick_idx;
  logic [OWN_W-1:0]      next_ptr;
  logic                  beat;

  // Owner-indexed views of the request inputs.
  always_comb begin
    req_own  = req[owner_q];
    data_own = '0;
    owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == OWN_W'(i)) begin
        data_own    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        owner_oh[i] = 1'b1;
      end
    end
  end

  // First requesting index at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int cand;
    cand     = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_vld && req[OWN_W'(cand)]) begin
        pick_vld = 1'b1;
        pick_idx = OWN_W'(cand);
      end
    end
  end

  assign next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + OWN_W'(1);
  assign beat     = (state_q == BURST) && req_own && !full;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt     = '0;
    w_en    = 1'b0;
    data_in = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        gnt     = owner_oh;
        data_in = data_own;
        w_en    = beat;
        if (!req_own) begin
          // Owner withdrew: give up the grant without writing this cycle.
          state_d = IDLE;
          ptr_d   = next_ptr;
        end else if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = IDLE;
            ptr_d   = next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] stat_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      stat_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (beat && owner_oh[i] && (stat_q[i] != 16'hFFFF)) begin
          stat_q[i] <= stat_q[i] + 16'd1;
        end
      end
    end
  end

  assign stat_cnt = stat_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  typedef struct packed {
    logic [NR-1:0] g;
    logic [DW-1:0] d;
  } exp_t;

  logic             wclk;
  logic             wrst_n;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic             full;
  logic [NR-1:0]    gnt, gnt1;
  logic             w_en, w_en1;
  logic [DW-1:0]    data_in, data_in1;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NR*16-1:0] stat_cnt, stat_cnt1;
`endif

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(BL)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .full(full), .w_en(w_en), .data_in(data_in)
`ifdef FIFO_WR_ARB_STATS_EN
    , .stat_cnt(stat_cnt)
`endif
  );

  // Single-beat instance sharing the same stimulus.
  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(1)) dut1 (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data),
    .gnt(gnt1), .full(full), .w_en(w_en1), .data_in(data_in1)
`ifdef FIFO_WR_ARB_STATS_EN
    , .stat_cnt(stat_cnt1)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_errors = 0;
  int seq  [NR];
  int pseq [NR];
  int rem  [NR];
  int beats;
  exp_t exp_q [$];
  logic [NR-1:0] prev_gnt, last_gnt, last_gnt1;
  logic          last_wen, last_wen1;
  logic [DW-1:0] last_data1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int i, input int s);
    return DW'((i << 5) | (s & 31));
  endfunction

  task automatic drive_req();
    for (int i = 0; i < NR; i++) begin
      req[i] = (rem[i] > 0);
      req_data[i*DW +: DW] = mk(i, seq[i]);
    end
  endtask

  task automatic push_beats(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(exp_t'{g: NR'(1 << i), d: mk(i, pseq[i])});
      pseq[i]++;
    end
  endtask

  // One clock: sample/score at negedge, advance requester data after posedge.
  task automatic cycle();
    logic [NR-1:0] acc;
    exp_t e;
    @(negedge wclk);
    acc = '0;
    if (w_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(data_in), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_gnt", 32'(gnt), 32'(e.g));
        check("wr_data", 32'(data_in), 32'(e.d));
      end
      acc = gnt;
      beats++;
    end
    if (gnt != '0) check("gnt_onehot", 32'($countones(gnt)), 32'd1);
    if (gnt != '0 && prev_gnt != '0) check("gnt_no_direct_switch", 32'(gnt), 32'(prev_gnt));
    prev_gnt   = gnt;
    last_gnt   = gnt;
    last_wen   = w_en;
    last_gnt1  = gnt1;
    last_wen1  = w_en1;
    last_data1 = data_in1;
    @(posedge wclk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        seq[i]++;
        if (rem[i] > 0) rem[i]--;
      end
    end
    drive_req();
  endtask

  task automatic do_reset();
    for (int i = 0; i < NR; i++) begin
      seq[i] = 0; pseq[i] = 0; rem[i] = 0;
    end
    exp_q.delete();
    beats = 0;
    prev_gnt = '0;
    full = 1'b0;
    drive_req();
    wrst_n = 1'b0;
    #3;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_wen", 32'(w_en), 32'd0);
    check("rst_data", 32'(data_in), 32'd0);
    check("rst_gnt1", 32'(gnt1), 32'd0);
    @(posedge wclk);
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wrst_n = 1'b1;
    req = '0;
    req_data = '0;
    full = 1'b0;
    #2;

    // Single requester: 4-beat burst, one idle cycle, re-grant to 0.
    do_reset();
    rem[0] = 1000;
    push_beats(0, 8);
    drive_req();
    cycle();
    check("a_gnt_first_cycle", 32'(last_gnt), 32'd0);
    for (int k = 0; k < BL; k++) begin
      cycle();
      check("a_gnt_burst1", 32'(last_gnt), 32'b0001);
      check("a_wen_burst1", 32'(last_wen), 32'd1);
    end
    cycle();
    check("a_gnt_gap", 32'(last_gnt), 32'd0);
    for (int k = 0; k < BL; k++) begin
      cycle();
      check("a_gnt_burst2", 32'(last_gnt), 32'b0001);
      check("a_wen_burst2", 32'(last_wen), 32'd1);
    end
    rem[0] = 0;
    drive_req();
    cycle();
    check("a_gnt_after", 32'(last_gnt), 32'd0);
    check("a_queue_empty", 32'(exp_q.size()), 32'd0);

    // All requesting: order 0,1,2,3,0 with one idle cycle each; BURST_LEN=1 instance alternates.
    do_reset();
    begin
      int zeros;
      zeros = 0;
      for (int i = 0; i < NR; i++) rem[i] = 1000;
      for (int b = 0; b < 5; b++) push_beats(b % NR, BL);
      drive_req();
      for (int k = 0; k < 5 * (BL + 1); k++) begin
        cycle();
        if (last_gnt == '0) zeros++;
        check("b1_gnt", 32'(last_gnt1), (k % 2 == 1) ? 32'(1 << ((k / 2) % NR)) : 32'd0);
        check("b1_wen", 32'(last_wen1), 32'(k % 2));
        if (k % 2 == 0) check("b1_data_idle", 32'(last_data1), 32'd0);
      end
      check("b_idle_cycles", 32'(zeros), 32'd5);
      check("b_beats", 32'(beats), 32'(5 * BL));
      for (int i = 0; i < NR; i++) rem[i] = 0;
      drive_req();
      cycle();
      check("b_queue_empty", 32'(exp_q.size()), 32'd0);
    end

    // Full stall after beat 2: grant held, no writes, data order preserved.
    do_reset();
    rem[1] = 1000;
    push_beats(1, BL);
    drive_req();
    for (int n = 0; n < 10 && beats < 2; n++) cycle();
    check("c_beats_pre_stall", 32'(beats), 32'd2);
    full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("c_stall_wen", 32'(last_wen), 32'd0);
      check("c_stall_gnt", 32'(last_gnt), 32'b0010);
    end
    full = 1'b0;
    for (int n = 0; n < 10 && beats < BL; n++) cycle();
    check("c_beats_total", 32'(beats), 32'(BL));
    rem[1] = 0;
    drive_req();
    cycle();
    check("c_gnt_end", 32'(last_gnt), 32'd0);
    check("c_queue_empty", 32'(exp_q.size()), 32'd0);

    // Owner 2 drops after one beat; requester 3 is next.
    do_reset();
    rem[2] = 1000;
    rem[3] = 1000;
    push_beats(2, 1);
    push_beats(3, BL);
    drive_req();
    cycle();
    cycle();
    check("d_first_gnt", 32'(last_gnt), 32'b0100);
    check("d_first_wen", 32'(last_wen), 32'd1);
    rem[2] = 0;
    drive_req();
    cycle();
    check("d_drop_no_write", 32'(last_wen), 32'd0);
    cycle();
    check("d_gap_gnt", 32'(last_gnt), 32'd0);
    cycle();
    check("d_next_gnt", 32'(last_gnt), 32'b1000);
    for (int k = 1; k < BL; k++) cycle();
    rem[3] = 0;
    drive_req();
    cycle();
    check("d_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-burst with owner 3; arbitration restarts at requester 0.
    do_reset();
    rem[3] = 1000;
    push_beats(3, 2);
    drive_req();
    cycle();
    cycle();
    cycle();
    check("e_gnt_before_rst", 32'(gnt), 32'b1000);
    #2;
    wrst_n = 1'b0;
    #1;
    check("e_rst_wen", 32'(w_en), 32'd0);
    check("e_rst_gnt", 32'(gnt), 32'd0);
    check("e_rst_data", 32'(data_in), 32'd0);
    check("e_queue_empty", 32'(exp_q.size()), 32'd0);
    rem[0] = 1000;
    rem[3] = 1000;
    drive_req();
    @(posedge wclk);
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    push_beats(0, BL);
    cycle();
    check("e_no_gnt_before_edge", 32'(last_gnt), 32'd0);
    cycle();
    check("e_first_gnt", 32'(last_gnt), 32'b0001);
    for (int k = 1; k < BL; k++) cycle();
    for (int i = 0; i < NR; i++) rem[i] = 0;
    drive_req();
    cycle();
    check("e_queue_drained", 32'(exp_q.size()), 32'd0);

`ifdef FIFO_WR_ARB_STATS_EN
    // Ten beats from requester 1 counted in its statistics slice only.
    do_reset();
    rem[1] = 10;
    push_beats(1, 10);
    drive_req();
    for (int n = 0; n < 40 && beats < 10; n++) cycle();
    cycle();
    check("f_beats", 32'(beats), 32'd10);
    for (int i = 0; i < NR; i++) begin
      check("f_stat", 32'(stat_cnt[i*16 +: 16]), (i == 1) ? 32'd10 : 32'd0);
    end
    check("f_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
